// File: rtl/cpu.sv
// cpu: 5-stage in-order pipeline (IF/ID/EX/MEM/WB) with a built-in program ROM.
// The pipeline advances once every 32 clocks (sys_en); an iterative multiplier
// runs on the raw clock between sys_en edges.
module cpu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_bus_read,
  output logic [31:0] addr,
  output logic        cs,
  output logic        wr_rd,
  output logic [31:0] data_bus_write
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_MUL  = 4'd5,
    OP_ADDI = 4'd6,
    OP_LW   = 4'd7,
    OP_SW   = 4'd8
  } op_e;

  typedef enum logic [1:0] {M_IDLE, M_LOAD, M_BUSY, M_DONE} mul_state_e;

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [15:0] low);
    return {op, 2'b00, rd, rs, low};
  endfunction

  // ---------------- clock divider ----------------
  logic [4:0] div;
  logic       sys_en;
  assign sys_en = (div == 5'd31);

  // Free-running divider producing one sys_en clock in every 32.
  always_ff @(posedge clk) begin
    if (!rst) div <= '0;
    else      div <= div + 5'd1;
  end

  // ---------------- IF ----------------
  logic [5:0]  pc;
  logic [31:0] rom_word;
  logic [31:0] if_id;

  // Program ROM; every word past the setup sequence is SW r8,0(r7).
  always_comb begin
    rom_word = enc(OP_SW, 5'd8, 5'd7, 16'd0);
    case (pc)
      6'd0:  rom_word = enc(OP_ADDI, 5'd1, 5'd0, 16'd2001);
      6'd1:  rom_word = enc(OP_ADDI, 5'd2, 5'd0, 16'd4001);
      6'd2:  rom_word = enc(OP_ADDI, 5'd3, 5'd0, 16'd5001);
      6'd3:  rom_word = enc(OP_ADDI, 5'd4, 5'd0, 16'd3001);
      6'd4:  rom_word = enc(OP_MUL,  5'd5, 5'd1, {5'd2, 11'd0});
      6'd5:  rom_word = '0;
      6'd6:  rom_word = enc(OP_ADD,  5'd6, 5'd3, {5'd4, 11'd0});
      6'd7:  rom_word = enc(OP_ADDI, 5'd7, 5'd0, 16'h0DFF);
      6'd8:  rom_word = '0;
      6'd9:  rom_word = enc(OP_SUB,  5'd8, 5'd5, {5'd6, 11'd0});
      6'd10: rom_word = '0;
      6'd11: rom_word = '0;
      default: ;
    endcase
  end

  // Fetch: PC saturates at the last ROM word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc    <= '0;
      if_id <= '0;
    end else if (sys_en) begin
      if_id <= rom_word;
      if (pc != 6'd63) pc <= pc + 6'd1;
    end
  end

  // ---------------- ID ----------------
  logic [3:0]  id_op;
  logic [4:0]  id_rd, id_rs, id_rt;
  logic [31:0] id_imm;
  logic        unused_fields;
  assign id_op  = if_id[31:28];
  assign id_rd  = if_id[25:21];
  assign id_rs  = if_id[20:16];
  assign id_rt  = if_id[15:11];
  assign id_imm = {{16{if_id[15]}}, if_id[15:0]};
  assign unused_fields = &{1'b0, if_id[27:26]};

  logic [31:0] regs [32];
  logic [3:0]  wb_op;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_we;
  assign wb_we = (wb_op >= OP_ADD) && (wb_op <= OP_LW) && (wb_rd != 5'd0);

  logic [31:0] rs_val, rt_val, rd_val;

  // Register reads with WB bypass; r0 always reads zero.
  always_comb begin
    rs_val = regs[id_rs];
    rt_val = regs[id_rt];
    rd_val = regs[id_rd];
    if (wb_we && wb_rd == id_rs) rs_val = wb_data;
    if (wb_we && wb_rd == id_rt) rt_val = wb_data;
    if (wb_we && wb_rd == id_rd) rd_val = wb_data;
    if (id_rs == 5'd0) rs_val = '0;
    if (id_rt == 5'd0) rt_val = '0;
    if (id_rd == 5'd0) rd_val = '0;
  end

  // Register file write-back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (sys_en && wb_we) begin
      regs[wb_rd] <= wb_data;
    end
  end

  logic [3:0]  ex_op;
  logic [4:0]  ex_rd;
  logic [31:0] ex_a, ex_b, ex_imm, ex_st;

  // ID/EX pipeline register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_op <= '0; ex_rd <= '0; ex_a <= '0; ex_b <= '0; ex_imm <= '0; ex_st <= '0;
    end else if (sys_en) begin
      ex_op  <= id_op;
      ex_rd  <= id_rd;
      ex_a   <= rs_val;
      ex_b   <= rt_val;
      ex_imm <= id_imm;
      ex_st  <= rd_val;
    end
  end

  // ---------------- EX: multiplier ----------------
  mul_state_e  mul_state, mul_next;
  logic [31:0] mul_mcand, mul_prod;
  logic [15:0] mul_mplier;
  logic [3:0]  mul_cnt;

  // Multiplier state register.
  always_ff @(posedge clk) begin
    if (!rst) mul_state <= M_IDLE;
    else      mul_state <= mul_next;
  end

  // Multiplier sequencing; a sys_en edge that moves MUL into EX arms a load.
  always_comb begin
    mul_next = mul_state;
    case (mul_state)
      M_LOAD:  mul_next = M_BUSY;
      M_BUSY:  if (mul_cnt == 4'd15) mul_next = M_DONE;
      default: ;
    endcase
    if (sys_en) mul_next = (id_op == OP_MUL) ? M_LOAD : M_IDLE;
  end

  // Shift-add datapath, one multiplier bit per clock.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mul_mcand <= '0; mul_mplier <= '0; mul_prod <= '0; mul_cnt <= '0;
    end else begin
      case (mul_state)
        M_LOAD: begin
          mul_mcand  <= {16'd0, ex_a[15:0]};
          mul_mplier <= ex_b[15:0];
          mul_prod   <= '0;
          mul_cnt    <= '0;
        end
        M_BUSY: begin
          if (mul_mplier[0]) mul_prod <= mul_prod + mul_mcand;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          mul_cnt    <= mul_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // ---------------- EX: ALU ----------------
  logic [31:0] alu_b, alu_res, ex_result;

  // ALU and result select.
  always_comb begin
    alu_b = (ex_op == OP_ADDI || ex_op == OP_LW || ex_op == OP_SW) ? ex_imm : ex_b;
    case (ex_op)
      OP_SUB:  alu_res = ex_a - alu_b;
      OP_AND:  alu_res = ex_a & alu_b;
      OP_OR:   alu_res = ex_a | alu_b;
      default: alu_res = ex_a + alu_b;
    endcase
    ex_result = (ex_op == OP_MUL) ? mul_prod : alu_res;
  end

  // ---------------- MEM ----------------
  logic [3:0]  mem_op;
  logic [4:0]  mem_rd;
  logic [31:0] d_mem, mem_st;
  logic        mem_cs, mem_wr;

  // EX/MEM register; also drives the bus outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_op <= '0; mem_rd <= '0; d_mem <= '0; mem_st <= '0;
      mem_cs <= 1'b1; mem_wr <= 1'b1;
    end else if (sys_en) begin
      mem_op <= ex_op;
      mem_rd <= ex_rd;
      d_mem  <= ex_result;
      mem_st <= ex_st;
      mem_cs <= !(ex_op == OP_LW || ex_op == OP_SW);
      mem_wr <= (ex_op != OP_SW);
    end
  end

  assign addr           = d_mem;
  assign data_bus_write = mem_st;
  assign cs             = mem_cs;
  assign wr_rd          = mem_wr;

  // MEM/WB register; LW data is captured from the bus here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_op <= '0; wb_rd <= '0; wb_data <= '0;
    end else if (sys_en) begin
      wb_op   <= mem_op;
      wb_rd   <= mem_rd;
      wb_data <= (mem_op == OP_LW) ? data_bus_read : d_mem;
    end
  end

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: checks reset behaviour, sys_en cadence, the built-in program's bus
// activity, multiplier timing and mid-run resets.
module tb_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_bus_read = '0;
  logic [31:0] addr, data_bus_write;
  logic        cs, wr_rd;

  cpu dut (
    .clk(clk), .rst(rst), .data_bus_read(data_bus_read),
    .addr(addr), .cs(cs), .wr_rd(wr_rd), .data_bus_write(data_bus_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          clk_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        cs;
    logic        wr;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   n = 0;
  bit   chk_sys = 1'b0;

  localparam logic [31:0] PROD  = 32'h007A2971;
  localparam logic [31:0] DIFF  = 32'h007A0A2F;
  localparam logic [31:0] SADDR = 32'h00000DFF;

  task automatic compare(input string name, input vec_t e);
    tests++;
    if (addr !== e.addr || data_bus_write !== e.wdata || cs !== e.cs || wr_rd !== e.wr) begin
      fails++;
      $display("FAIL %s clk=%0d: got addr=%h data=%h cs=%b wr_rd=%b, want addr=%h data=%h cs=%b wr_rd=%b",
               name, n, addr, data_bus_write, cs, wr_rd, e.addr, e.wdata, e.cs, e.wr);
    end
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    @(negedge clk);
    if (chk_sys && n <= 100) begin
      tests++;
      if (dut.sys_en !== ((n % 32) == 31)) begin
        fails++;
        $display("FAIL sys_en clk=%0d: got %b want %b", n, dut.sys_en, ((n % 32) == 31));
      end
    end
  endtask

  task automatic hold_reset(input string name, input int cycles);
    vec_t r;
    r = '{clk_n: 0, addr: '0, wdata: '0, cs: 1'b1, wr: 1'b1};
    rst = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    compare(name, r);
    rst = 1'b1;
    n = 0;
  endtask

  task automatic run_table(input string tag);
    vec_t e;
    foreach (vecs[i]) begin
      sb.push_back(vecs[i]);
      while (n < vecs[i].clk_n) step();
      e = sb.pop_front();
      compare($sformatf("%s@%0d", tag, e.clk_n), e);
    end
  endtask

  task automatic advance_to(input int target);
    while (n < target) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Bus state after n clocks from release (sys_en edge k lands at clk 32k;
    // instruction k-3 sits in MEM after edge k).
    vecs.push_back('{0,    32'd0,    32'd0, 1'b1, 1'b1});
    vecs.push_back('{31,   32'd0,    32'd0, 1'b1, 1'b1});
    vecs.push_back('{32,   32'd0,    32'd0, 1'b1, 1'b1});
    vecs.push_back('{95,   32'd0,    32'd0, 1'b1, 1'b1});
    vecs.push_back('{96,   32'd2001, 32'd0, 1'b1, 1'b1});
    vecs.push_back('{127,  32'd2001, 32'd0, 1'b1, 1'b1});
    vecs.push_back('{128,  32'd4001, 32'd0, 1'b1, 1'b1});
    vecs.push_back('{160,  32'd5001, 32'd0, 1'b1, 1'b1});
    vecs.push_back('{192,  32'd3001, 32'd0, 1'b1, 1'b1});
    vecs.push_back('{223,  32'd3001, 32'd0, 1'b1, 1'b1});
    vecs.push_back('{224,  PROD,     32'd0, 1'b1, 1'b1});
    vecs.push_back('{256,  32'd0,    32'd0, 1'b1, 1'b1});
    vecs.push_back('{288,  32'd8002, 32'd0, 1'b1, 1'b1});
    vecs.push_back('{320,  SADDR,    32'd0, 1'b1, 1'b1});
    vecs.push_back('{384,  32'd7997999, 32'd0, 1'b1, 1'b1});
    vecs.push_back('{448,  32'd0,    32'd0, 1'b1, 1'b1});
    vecs.push_back('{479,  32'd0,    32'd0, 1'b1, 1'b1});
    vecs.push_back('{480,  SADDR,    DIFF,  1'b0, 1'b0});
    vecs.push_back('{1152, SADDR,    DIFF,  1'b0, 1'b0});
    vecs.push_back('{1280, SADDR,    DIFF,  1'b0, 1'b0});

    data_bus_read = $urandom;
    @(negedge clk);

    // Power-on reset, sys_en cadence and the full program run.
    hold_reset("por", 3);
    chk_sys = 1'b1;
    run_table("run1");
    chk_sys = 1'b0;

    // Reset during sys period 10 for 2 clocks.
    hold_reset("restart2", 2);
    advance_to(32 * 10 + 3);
    hold_reset("mid_reset", 2);
    run_table("run2");

    // Reset while the multiply is iterating; it must leave no trace.
    hold_reset("restart3", 2);
    advance_to(32 * 6 + 8);
    hold_reset("mul_abort", 2);
    run_table("run3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 clk  input  1  single system clock; every register in the block is clocked on its rising edge.
REQ-002 rst  input  1  reset; synchronous and active-low: rst=0 sampled on a rising clk edge resets the block.
REQ-003 data_bus_read  input  32  load data from the external bus, sampled for LW.
REQ-004 addr  output  32  bus address: registered ALU result of the MEM-stage instruction.
REQ-005 cs  output  1  active-low bus chip select: 0 while the MEM-stage instruction is LW or SW.
REQ-006 wr_rd  output  1  bus direction: 0 = write (SW in MEM), 1 = read or idle.
REQ-007 data_bus_write  output  32  store data: registered rd-register value of the MEM-stage instruction.

Function
REQ-008 Internal divider: 5-bit counter div counts 0..31 on every clk; sys_en=1 when div==31; all pipeline stages advance only on clk edges with sys_en=1.
REQ-009 Pipeline: 5 stages IF, ID, EX, MEM, WB; no branches, no stalls, no forwarding.
REQ-010 Register file: 32x32; r0 reads 0 and ignores writes; WB write is bypassed to same-cycle ID reads.
REQ-011 Consequence of REQ-010: an instruction may use the result of the instruction 3 or more slots earlier; the program is NOP-padded accordingly.
REQ-012 Encoding: op=[31:28], rd=[25:21], rs=[20:16], rt=[15:11], imm=[15:0] sign-extended to 32 bits.
REQ-013 op 0 NOP; 1 ADD rd=rs+rt; 2 SUB rd=rs-rt; 3 AND; 4 OR; 5 MUL rd=rs[15:0]*rt[15:0] (unsigned, 32-bit product); 6 ADDI rd=rs+imm; 7 LW rd=bus[rs+imm]; 8 SW bus[rs+imm]=rd; ops 9..15 execute as NOP.
REQ-014 All add/sub/logic is 32-bit, wrap-around, with no flags.
REQ-015 MUL: iterative shift-add on clk, 1 bit per clk; loads operands on the clk after the sys_en that places MUL in EX; done within 16 clks; result is captured into MEM at the next sys_en.
REQ-016 EX result mux: MUL result for op 5, ALU result otherwise; the ALU's second operand is imm for ops 6/7/8 and rt otherwise.
REQ-017 LW: data_bus_read is captured on the sys_en edge moving the instruction from MEM to WB, then written to rd in WB.
REQ-018 Program ROM: 64 x 32, built in, indexed by PC[5:0]; PC increments by 1 per sys_en and saturates at 63.
REQ-019 ROM words 0..11: ADDI r1,r0,2001; ADDI r2,r0,4001; ADDI r3,r0,5001; ADDI r4,r0,3001; MUL r5,r1,r2; NOP; ADD r6,r3,r4; ADDI r7,r0,0x0DFF; NOP; SUB r8,r5,r6; NOP; NOP.
REQ-020 ROM words 12..63 are all SW r8,0(r7), so the bus store repeats indefinitely.
REQ-021 Bus outputs change only on sys_en edges; for non-memory MEM-stage instructions, addr = ALU result, cs=1, wr_rd=1.

Reset
REQ-022 On rst=0: div=0, PC=0, all pipeline registers = NOP, all registers = 0, multiplier idle, addr=0, data_bus_write=0, cs=1, wr_rd=1.
REQ-023 Reset asserted mid-operation aborts everything, including an in-flight multiply; execution restarts from PC 0 after release.
REQ-024 A multiply in flight when rst=0 is sampled produces no result.

Verification
REQ-025 Hold rst=0, then release -> outputs stay at reset values until the first sys_en (clk 32).
REQ-026 Run 36 sys_en periods after release -> addr=0x00000DFF, data_bus_write=0x007A0A2F (2001*4001-(5001+3001)=7997999), cs=0, wr_rd=0.
REQ-027 Run a further 4 sys_en periods -> same values held (repeated stores).
REQ-028 Assert rst=0 at sys period 10 for 2 clks, then release -> reset values, and the store sequence reappears 15 sys periods later.
REQ-029 Check MUL timing -> product 8006001 (0x007A2971) present in d_mem exactly one sys_en after MUL enters EX.
REQ-030 Check the sys_en divider -> sys_en is high for exactly 1 clk in every 32, with the first pulse at clk 31 after release.
